local_injector: RTL and testbench

- Traffic-source end of the router2router link, driving a router's LOCAL downstream input.
- Accepts packet descriptors into a small FIFO and segments each packet into HEAD/BODY/TAIL (or HEADTAIL) flits.
- Selects an idle downstream VC, locks it for the whole packet, and honours per-VC on/off backpressure.
- Used by node models and the mesh testbench as the injection point for every router.

---
 rtl/noc_params.sv | 52 +++++
 rtl/injector_fifo.sv | 59 +++++
 rtl/local_injector.sv | 212 +++++++++++++++++++++
 tb/tb_local_injector.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_params.sv
`default_nettype none
// ============================================================================
//  Module      : noc_params (package)
//  Description : Mesh-wide NoC parameters, flit types and small helpers shared
//                by the routers and the local injector.
//  Contents    : MESH_SIZE_X/Y, DEST_ADDR_SIZE_X/Y, VC_NUM, VC_SIZE,
//                FLIT_DATA_SIZE, flit_label_t, flit_t, len_width(),
//                head_data()
//  Revision    : 1.0 - initial release
// ============================================================================
package noc_params;

    localparam int MESH_SIZE_X      = 4;
    localparam int MESH_SIZE_Y      = 4;
    localparam int DEST_ADDR_SIZE_X = $clog2(MESH_SIZE_X);
    localparam int DEST_ADDR_SIZE_Y = $clog2(MESH_SIZE_Y);
    localparam int VC_NUM           = 2;
    localparam int VC_SIZE          = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int FLIT_DATA_SIZE   = 16;

    typedef enum logic [1:0] {
        HEAD     = 2'b00,
        BODY     = 2'b01,
        TAIL     = 2'b10,
        HEADTAIL = 2'b11
    } flit_label_t;

    typedef struct packed {
        flit_label_t                 flit_label;
        logic [VC_SIZE-1:0]          vc_id;
        logic [FLIT_DATA_SIZE-1:0]   data;
    } flit_t;

    // Width of a packet-length field able to hold 0..max_pkt_len.
    function automatic int len_width(input int max_pkt_len);
        return $clog2(max_pkt_len + 1);
    endfunction

    // Head flit payload layout: x destination in the low bits, y above it.
    function automatic logic [FLIT_DATA_SIZE-1:0] head_data(
        input logic [DEST_ADDR_SIZE_X-1:0] x_dest,
        input logic [DEST_ADDR_SIZE_Y-1:0] y_dest
    );
        logic [FLIT_DATA_SIZE-1:0] d;
        d = '0;
        d[DEST_ADDR_SIZE_X-1:0]                                 = x_dest;
        d[DEST_ADDR_SIZE_X+DEST_ADDR_SIZE_Y-1:DEST_ADDR_SIZE_X] = y_dest;
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/injector_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : injector_fifo
//  Description : Generic synchronous FIFO with full/empty flags, wrap-around
//                pointers and simultaneous push/pop (also when full). The
//                head entry is presented combinationally on rd_data.
//  Ports       : clk, rst (async active-low), push/push_data, pop,
//                rd_data, full, empty
//  Revision    : 1.0 - initial release
// ============================================================================
module injector_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; only entries between the pointers are read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);

endmodule
`default_nettype wire

// File: rtl/local_injector.sv
`default_nettype none
// ============================================================================
//  Module      : local_injector
//  Description : Traffic source for a router LOCAL input. Queues packet
//                descriptors, allocates an idle downstream VC round-robin,
//                locks it for the packet and emits HEAD/BODY/TAIL or HEADTAIL
//                flits under per-VC on/off backpressure.
//  Ports       : clk, rst (async active-low)
//                pkt_valid_i/pkt_ready_o, pkt_x_dest_i, pkt_y_dest_i,
//                pkt_len_i         - descriptor input
//                pld_valid_i/pld_ready_o, pld_i - payload words
//                data_o, is_valid_o - flit output
//                is_on_off_i, is_allocatable_i - downstream VC status
//                err_o, sent_pkts_o - rejected-descriptor pulse, tail count
//  Revision    : 1.0 - initial release
// ============================================================================
module local_injector
    import noc_params::*;
#(
    parameter  int QUEUE_DEPTH = 4,
    parameter  int MAX_PKT_LEN = 8,
    parameter  int X_CURRENT   = MESH_SIZE_X / 2,
    parameter  int Y_CURRENT   = MESH_SIZE_Y / 2,
    localparam int LEN_W       = len_width(MAX_PKT_LEN)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pkt_valid_i,
    output logic                        pkt_ready_o,
    input  logic [DEST_ADDR_SIZE_X-1:0] pkt_x_dest_i,
    input  logic [DEST_ADDR_SIZE_Y-1:0] pkt_y_dest_i,
    input  logic [LEN_W-1:0]            pkt_len_i,
    input  logic                        pld_valid_i,
    output logic                        pld_ready_o,
    input  logic [FLIT_DATA_SIZE-1:0]   pld_i,
    output flit_t                       data_o,
    output logic                        is_valid_o,
    input  logic [VC_NUM-1:0]           is_on_off_i,
    input  logic [VC_NUM-1:0]           is_allocatable_i,
    output logic                        err_o,
    output logic [15:0]                 sent_pkts_o
);

    localparam logic [DEST_ADDR_SIZE_X-1:0] SRC_X   = DEST_ADDR_SIZE_X'(X_CURRENT);
    localparam logic [DEST_ADDR_SIZE_Y-1:0] SRC_Y   = DEST_ADDR_SIZE_Y'(Y_CURRENT);
    localparam logic [LEN_W-1:0]            LEN_MAX = LEN_W'(MAX_PKT_LEN);
    localparam logic [LEN_W-1:0]            LEN_ONE = LEN_W'(1);

    typedef struct packed {
        logic [DEST_ADDR_SIZE_X-1:0] x_dest;
        logic [DEST_ADDR_SIZE_Y-1:0] y_dest;
        logic [LEN_W-1:0]            len;
    } desc_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state, state_n;
    desc_t               in_desc, head_desc;
    logic                fifo_full, fifo_empty;
    logic                push, pop, desc_bad;
    logic [VC_NUM-1:0]   reserved, reserved_n, eligible;
    logic [VC_SIZE-1:0]  rr_ptr, rr_ptr_n, lock_vc, lock_vc_n, pick_vc;
    logic                pick_found;
    logic [LEN_W-1:0]    remaining, remaining_n;
    flit_t               flit_q, flit_n;
    logic                valid_q, valid_n;
    logic                err_q;
    logic [15:0]         sent_q, sent_n;

    // ------------------------------------------------------------------
    // Descriptor intake
    // ------------------------------------------------------------------
    assign in_desc  = '{x_dest: pkt_x_dest_i, y_dest: pkt_y_dest_i, len: pkt_len_i};
    assign desc_bad = (pkt_len_i == '0) || (pkt_len_i > LEN_MAX) ||
                      ((pkt_x_dest_i == SRC_X) && (pkt_y_dest_i == SRC_Y));

    // A full FIFO can still accept when the head is popped this cycle.
    assign pkt_ready_o = rst & (~fifo_full | pop);
    assign push        = pkt_valid_i & pkt_ready_o & ~desc_bad;

    injector_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH ($bits(desc_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (in_desc),
        .pop       (pop),
        .rd_data   (head_desc),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Round-robin VC pick, searching from rr_ptr (one past the last grant).
    // A VC is only pickable when it is idle downstream, not already handed
    // out by us, and currently switched on.
    // ------------------------------------------------------------------
    assign eligible = is_allocatable_i & ~reserved & is_on_off_i;

    always_comb begin
        int                 idx;
        logic [VC_SIZE-1:0] cand;
        pick_found = 1'b0;
        pick_vc    = '0;
        idx        = 0;
        cand       = '0;
        for (int i = 0; i < VC_NUM; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= VC_NUM) idx = idx - VC_NUM;
            cand = VC_SIZE'(idx);
            if (!pick_found && eligible[cand]) begin
                pick_found = 1'b1;
                pick_vc    = cand;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_n     = state;
        flit_n      = '0;
        valid_n     = 1'b0;
        remaining_n = remaining;
        lock_vc_n   = lock_vc;
        rr_ptr_n    = rr_ptr;
        sent_n      = sent_q;
        pop         = 1'b0;
        pld_ready_o = 1'b0;
        // A reservation lasts until the router shows the VC as busy once.
        reserved_n  = reserved & is_allocatable_i;

        case (state)
            IDLE: begin
                if (!fifo_empty && pick_found) begin
                    pop                 = 1'b1;
                    valid_n             = 1'b1;
                    flit_n.vc_id        = pick_vc;
                    flit_n.data         = head_data(head_desc.x_dest, head_desc.y_dest);
                    reserved_n[pick_vc] = 1'b1;
                    lock_vc_n           = pick_vc;
                    rr_ptr_n            = (int'(pick_vc) == VC_NUM - 1) ? '0 : pick_vc + 1'b1;
                    remaining_n         = head_desc.len - 1'b1;
                    if (head_desc.len == LEN_ONE) begin
                        flit_n.flit_label = HEADTAIL;
                        sent_n            = sent_q + 16'd1;
                    end else begin
                        flit_n.flit_label = HEAD;
                        state_n           = SEND;
                    end
                end
            end
            SEND: begin
                if (is_on_off_i[lock_vc] && pld_valid_i) begin
                    pld_ready_o  = 1'b1;
                    valid_n      = 1'b1;
                    flit_n.vc_id = lock_vc;
                    flit_n.data  = pld_i;
                    remaining_n  = remaining - 1'b1;
                    if (remaining == LEN_ONE) begin
                        flit_n.flit_label = TAIL;
                        sent_n            = sent_q + 16'd1;
                        state_n           = IDLE;
                    end else begin
                        flit_n.flit_label = BODY;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            flit_q    <= '0;
            valid_q   <= 1'b0;
            remaining <= '0;
            lock_vc   <= '0;
            rr_ptr    <= '0;
            reserved  <= '0;
            sent_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_n;
            flit_q    <= flit_n;
            valid_q   <= valid_n;
            remaining <= remaining_n;
            lock_vc   <= lock_vc_n;
            rr_ptr    <= rr_ptr_n;
            reserved  <= reserved_n;
            sent_q    <= sent_n;
            err_q     <= pkt_valid_i & pkt_ready_o & desc_bad;
        end
    end

    assign data_o      = flit_q;
    assign is_valid_o  = valid_q;
    assign err_o       = err_q;
    assign sent_pkts_o = sent_q;

endmodule
`default_nettype wire

// File: tb/tb_local_injector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_local_injector
//  Description : Directed self-checking bench for local_injector.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_local_injector;
    import noc_params::*;

    logic                        clk = 1'b0;
    logic                        rst = 1'b0;
    logic                        pkt_valid;
    logic                        pkt_ready;
    logic [DEST_ADDR_SIZE_X-1:0] x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0] y_dest;
    logic [3:0]                  len;
    logic                        pld_valid;
    logic                        pld_ready;
    logic [FLIT_DATA_SIZE-1:0]   pld;
    flit_t                       flit;
    logic                        is_valid;
    logic [VC_NUM-1:0]           on_off;
    logic [VC_NUM-1:0]           alloc;
    logic                        err;
    logic [15:0]                 sent;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    local_injector dut (
        .clk              (clk),
        .rst              (rst),
        .pkt_valid_i      (pkt_valid),
        .pkt_ready_o      (pkt_ready),
        .pkt_x_dest_i     (x_dest),
        .pkt_y_dest_i     (y_dest),
        .pkt_len_i        (len),
        .pld_valid_i      (pld_valid),
        .pld_ready_o      (pld_ready),
        .pld_i            (pld),
        .data_o           (flit),
        .is_valid_o       (is_valid),
        .is_on_off_i      (on_off),
        .is_allocatable_i (alloc),
        .err_o            (err),
        .sent_pkts_o      (sent)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_flit(input string tag, input flit_label_t lbl,
                              input logic [VC_SIZE-1:0] vc, input logic [15:0] d);
        chk({tag, "_valid"}, 32'(is_valid), 32'd1);
        chk({tag, "_label"}, 32'(flit.flit_label), 32'(lbl));
        chk({tag, "_vc"},    32'(flit.vc_id), 32'(vc));
        chk({tag, "_data"},  32'(flit.data), 32'(d));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle with no VC idle downstream clears all reservations.
    task automatic release_vcs();
        alloc = 2'b00;
        tick();
        alloc = 2'b11;
    endtask

    task automatic offer(input logic [1:0] x, input logic [1:0] y, input logic [3:0] l);
        pkt_valid = 1'b1;
        x_dest    = x;
        y_dest    = y;
        len       = l;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pkt_valid = 1'b0; x_dest = '0; y_dest = '0; len = '0;
        pld_valid = 1'b0; pld = '0; on_off = 2'b11; alloc = 2'b11;

        // ---------------- reset state ----------------
        #12;
        chk("rst_is_valid",  32'(is_valid),  32'd0);
        chk("rst_data",      32'(flit),      32'd0);
        chk("rst_pkt_ready", 32'(pkt_ready), 32'd0);
        chk("rst_pld_ready", 32'(pld_ready), 32'd0);
        chk("rst_err",       32'(err),       32'd0);
        chk("rst_sent",      32'(sent),      32'd0);
        tick(); tick();
        rst = 1'b1;
        #1 chk("ready_after_reset", 32'(pkt_ready), 32'd1);

        // ---------------- single HEADTAIL ----------------
        offer(2'd1, 2'd0, 4'd1);
        tick();
        pkt_valid = 1'b0;
        chk("t1_not_yet", 32'(is_valid), 32'd0);
        tick();
        check_flit("t1_headtail", HEADTAIL, 1'b0, 16'h0001);
        chk("t1_sent", 32'(sent), 32'd1);
        tick();
        chk("t1_idle_after", 32'(is_valid), 32'd0);
        release_vcs();

        // ---------------- len=4 continuous payload ----------------
        offer(2'd3, 2'd1, 4'd4);
        pld_valid = 1'b1; pld = 16'hA0A0;
        #1 chk("t2_pld_ready_idle", 32'(pld_ready), 32'd0);
        tick();
        pkt_valid = 1'b0;
        tick();
        check_flit("t2_head", HEAD, 1'b1, 16'h0007);
        chk("t2_pld_ready_send", 32'(pld_ready), 32'd1);
        tick();
        check_flit("t2_body_a", BODY, 1'b1, 16'hA0A0);
        pld = 16'hB1B1;
        tick();
        check_flit("t2_body_b", BODY, 1'b1, 16'hB1B1);
        pld = 16'hC2C2;
        tick();
        check_flit("t2_tail_c", TAIL, 1'b1, 16'hC2C2);
        chk("t2_sent", 32'(sent), 32'd2);
        pld_valid = 1'b0;
        tick();
        chk("t2_idle_after", 32'(is_valid), 32'd0);
        release_vcs();

        // ---------------- VC0 switched off for 3 cycles mid-packet ----------------
        offer(2'd0, 2'd1, 4'd4);
        pld_valid = 1'b1; pld = 16'hD3D3;
        tick();
        pkt_valid = 1'b0;
        tick();
        check_flit("t3_head", HEAD, 1'b0, 16'h0004);
        tick();
        check_flit("t3_body_d", BODY, 1'b0, 16'hD3D3);
        on_off = 2'b10;
        pld = 16'hE4E4;
        #1 chk("t3_pld_ready_off", 32'(pld_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_stalled_valid", 32'(is_valid), 32'd0);
            chk("t3_stalled_pld_ready", 32'(pld_ready), 32'd0);
        end
        on_off = 2'b11;
        #1 chk("t3_pld_ready_on", 32'(pld_ready), 32'd1);
        tick();
        check_flit("t3_body_e", BODY, 1'b0, 16'hE4E4);
        pld = 16'hF5F5;
        tick();
        check_flit("t3_tail_f", TAIL, 1'b0, 16'hF5F5);
        chk("t3_sent", 32'(sent), 32'd3);
        pld_valid = 1'b0;
        release_vcs();

        // ---------------- HEADTAIL on VC1 (round-robin advance) ----------------
        offer(2'd0, 2'd3, 4'd1);
        tick();
        pkt_valid = 1'b0;
        tick();
        check_flit("t4_headtail", HEADTAIL, 1'b1, 16'h000C);
        chk("t4_sent", 32'(sent), 32'd4);
        release_vcs();

        // ---------------- back-to-back len=2, VC0 slow to go busy ----------------
        offer(2'd1, 2'd1, 4'd2);
        tick();
        offer(2'd2, 2'd1, 4'd2);
        tick();
        pkt_valid = 1'b0;
        pld_valid = 1'b1; pld = 16'h1111;
        check_flit("t5_p1_head", HEAD, 1'b0, 16'h0005);
        tick();
        check_flit("t5_p1_tail", TAIL, 1'b0, 16'h1111);
        pld = 16'h2222;
        tick();
        check_flit("t5_p2_head", HEAD, 1'b1, 16'h0006);
        offer(2'd3, 2'd3, 4'd1);
        tick();
        check_flit("t5_p2_tail", TAIL, 1'b1, 16'h2222);
        chk("t5_sent_p2", 32'(sent), 32'd6);
        pkt_valid = 1'b0;
        pld_valid = 1'b0;
        tick();
        chk("t5_vc0_reserved_a", 32'(is_valid), 32'd0);
        tick();
        chk("t5_vc0_reserved_b", 32'(is_valid), 32'd0);
        alloc = 2'b10;
        tick();
        chk("t5_vc0_busy", 32'(is_valid), 32'd0);
        alloc = 2'b11;
        tick();
        check_flit("t5_p3_vc0_reuse", HEADTAIL, 1'b0, 16'h000F);
        chk("t5_sent_p3", 32'(sent), 32'd7);
        release_vcs();

        // ---------------- rejected descriptors, then FIFO fill ----------------
        alloc = 2'b00;
        offer(2'd1, 2'd0, 4'd0);
        #1 chk("t6_ready_empty", 32'(pkt_ready), 32'd1);
        tick();
        chk("t6_err_len0", 32'(err), 32'd1);
        len = 4'd9;
        tick();
        chk("t6_err_len9", 32'(err), 32'd1);
        offer(2'd2, 2'd2, 4'd2);
        tick();
        chk("t6_err_self_dest", 32'(err), 32'd1);
        offer(2'd1, 2'd0, 4'd1);
        for (int i = 0; i < 4; i++) begin
            #1 chk("t6_fill_ready", 32'(pkt_ready), 32'd1);
            tick();
        end
        #1 chk("t6_full_ready", 32'(pkt_ready), 32'd0);
        chk("t6_no_err_valid", 32'(err), 32'd0);
        tick();
        pkt_valid = 1'b0;

        // ---------------- reset flushes queued descriptors ----------------
        rst = 1'b0;
        #1 chk("t7_ready_in_reset", 32'(pkt_ready), 32'd0);
        tick();
        rst = 1'b1;
        alloc = 2'b11;
        tick();
        tick();
        chk("t7_flushed_no_flit", 32'(is_valid), 32'd0);
        chk("t7_sent_cleared", 32'(sent), 32'd0);

        // ---------------- reset mid-BODY ----------------
        offer(2'd1, 2'd2, 4'd4);
        pld_valid = 1'b1; pld = 16'h7777;
        tick();
        pkt_valid = 1'b0;
        tick();
        check_flit("t8_head", HEAD, 1'b0, 16'h0009);
        tick();
        check_flit("t8_body", BODY, 1'b0, 16'h7777);
        rst = 1'b0;
        #1;
        chk("t8_valid_in_reset", 32'(is_valid), 32'd0);
        chk("t8_data_in_reset", 32'(flit), 32'd0);
        chk("t8_pld_ready_in_reset", 32'(pld_ready), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        tick();
        chk("t8_no_tail", 32'(is_valid), 32'd0);
        chk("t8_pld_ready_idle", 32'(pld_ready), 32'd0);
        chk("t8_sent", 32'(sent), 32'd0);
        pld_valid = 1'b0;

        // ---------------- operation resumes from VC0 ----------------
        offer(2'd1, 2'd0, 4'd1);
        tick();
        pkt_valid = 1'b0;
        tick();
        check_flit("t9_headtail", HEADTAIL, 1'b0, 16'h0001);
        chk("t9_sent", 32'(sent), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
